// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants: fields, opcodes, functs, instruction IDs
package decode_pkg;

  localparam int REG_AW = 5;

  // Instruction field bit positions
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_ADDIU = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_OR    = 6'd4;
  localparam logic [5:0] OP_ANDI  = 6'd5;
  localparam logic [5:0] OP_ORI   = 6'd6;
  localparam logic [5:0] OP_SHIFT = 6'd7;
  localparam logic [5:0] OP_SLT   = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;

  // Function codes
  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_SUB  = 6'd1;
  localparam logic [5:0] FN_ADDU = 6'd2;
  localparam logic [5:0] FN_SUBU = 6'd3;
  localparam logic [5:0] FN_ZERO = 6'd0;
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd1;

  // Instruction IDs seen by the ALU
  localparam logic [31:0] ID_ADD   = 32'd1;
  localparam logic [31:0] ID_SUB   = 32'd2;
  localparam logic [31:0] ID_ADDU  = 32'd3;
  localparam logic [31:0] ID_SUBU  = 32'd4;
  localparam logic [31:0] ID_ADDI  = 32'd5;
  localparam logic [31:0] ID_ADDIU = 32'd6;
  localparam logic [31:0] ID_AND   = 32'd7;
  localparam logic [31:0] ID_OR    = 32'd8;
  localparam logic [31:0] ID_ANDI  = 32'd9;
  localparam logic [31:0] ID_ORI   = 32'd10;
  localparam logic [31:0] ID_SLL   = 32'd11;
  localparam logic [31:0] ID_SRL   = 32'd12;
  localparam logic [31:0] ID_SLT   = 32'd24;
  localparam logic [31:0] ID_SLTI  = 32'd25;

  // Source of operand 2; OPB_REG also marks instructions whose destination is rd
  typedef enum logic [1:0] {
    OPB_REG,
    OPB_SEXT,
    OPB_ZEXT,
    OPB_SHAMT
  } opb_sel_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] id;
    opb_sel_e    opb;
  } dec_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// rtl/decode_stage_reg_file.sv - 32x32 register file, two async reads, one sync write, write-through
// Ports: clk, reset (sync, active-high, clears all entries); we/waddr/wdata write port;
//        raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module reg_file
  import decode_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [31:0]       rdata_b
);

  logic [31:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-through lets a consumer issue in the same cycle its producer retires
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, operand fetch and hazard scoreboard ahead of the ALU
// Ports: clk, reset (sync, active-high); if_valid/if_ir/if_ready from fetch;
//        ex_valid/ex_ready and bundle ex_ir/ex_instr_id/ex_rs/ex_rt/ex_dst to execute;
//        wb_valid/wb_addr/wb_data writeback; illegal_seen sticky flag.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_ir,
  output logic              if_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_ir,
  output logic [31:0]       ex_instr_id,
  output logic [31:0]       ex_rs,
  output logic [31:0]       ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  output logic              illegal_seen
);

  logic [5:0]        op, fn;
  logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx, shamt, dst;
  logic [15:0]       imm;
  dec_t              dec;
  logic [31:0]       rs_data, rt_data, opb_val;
  logic [NREG-1:0]   pending, clr_vec, set_vec, busy;
  logic              wb_we, hazard, load_en, accept, issue;

  assign op     = if_ir[OPC_MSB:OPC_LSB];
  assign rs_idx = if_ir[RS_MSB:RS_LSB];
  assign rt_idx = if_ir[RT_MSB:RT_LSB];
  assign rd_idx = if_ir[RD_MSB:RD_LSB];
  assign shamt  = if_ir[SHAMT_MSB:SHAMT_LSB];
  assign fn     = if_ir[FUNCT_MSB:FUNCT_LSB];
  assign imm    = if_ir[IMM_MSB:IMM_LSB];

  always_comb begin
    dec.legal = 1'b0;
    dec.id    = '0;
    dec.opb   = OPB_REG;
    case (op)
      OP_RTYPE: if (fn <= FN_SUBU) begin
        dec.legal = 1'b1;
        dec.id    = ID_ADD + 32'(fn);
      end
      OP_ADDI:  begin dec.legal = 1'b1; dec.id = ID_ADDI;  dec.opb = OPB_SEXT; end
      OP_ADDIU: begin dec.legal = 1'b1; dec.id = ID_ADDIU; dec.opb = OPB_ZEXT; end
      OP_AND:   if (fn == FN_ZERO) begin dec.legal = 1'b1; dec.id = ID_AND; end
      OP_OR:    if (fn == FN_ZERO) begin dec.legal = 1'b1; dec.id = ID_OR; end
      OP_ANDI:  begin dec.legal = 1'b1; dec.id = ID_ANDI;  dec.opb = OPB_ZEXT; end
      OP_ORI:   begin dec.legal = 1'b1; dec.id = ID_ORI;   dec.opb = OPB_ZEXT; end
      OP_SHIFT: begin
        if (fn == FN_SLL) begin
          dec.legal = 1'b1; dec.id = ID_SLL; dec.opb = OPB_SHAMT;
        end else if (fn == FN_SRL) begin
          dec.legal = 1'b1; dec.id = ID_SRL; dec.opb = OPB_SHAMT;
        end
      end
      OP_SLT:   if (fn == FN_ZERO) begin dec.legal = 1'b1; dec.id = ID_SLT; end
      OP_SLTI:  begin dec.legal = 1'b1; dec.id = ID_SLTI;  dec.opb = OPB_SEXT; end
      default:  ;
    endcase
  end

  // R-type writes rd; immediates and shifts write the rt field
  assign dst   = (dec.opb == OPB_REG) ? rd_idx : rt_idx;
  assign wb_we = wb_valid && !reset;

  reg_file #(.NREG(NREG)) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_idx),
    .rdata_a (rs_data),
    .raddr_b (rt_idx),
    .rdata_b (rt_data)
  );

  always_comb begin
    case (dec.opb)
      OPB_SEXT:  opb_val = {{16{imm[15]}}, imm};
      OPB_ZEXT:  opb_val = {16'd0, imm};
      OPB_SHAMT: opb_val = {27'd0, shamt};
      default:   opb_val = rt_data;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      clr_vec[i] = wb_we && (wb_addr == REG_AW'(i));
      set_vec[i] = issue && (dst == REG_AW'(i));
    end
  end

  // A register being retired this cycle no longer blocks; its value comes via the bypass
  assign busy   = pending & ~clr_vec;
  assign hazard = dec.legal &&
                  (busy[rs_idx] || busy[dst] || ((dec.opb == OPB_REG) && busy[rt_idx]));

  assign load_en  = !ex_valid || ex_ready;
  // Holding off during reset keeps a stalled instruction upstream
  assign if_ready = !reset && load_en && !hazard;
  assign accept   = if_valid && if_ready;
  assign issue    = accept && dec.legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_ir        <= '0;
      ex_instr_id  <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      illegal_seen <= 1'b0;
      pending      <= '0;
    end else begin
      if (load_en) ex_valid <= issue;
      if (issue) begin
        ex_ir       <= if_ir;
        ex_instr_id <= dec.id;
        ex_rs       <= rs_data;
        ex_rt       <= opb_val;
        ex_dst      <= dst;
      end
      if (accept && !dec.legal) illegal_seen <= 1'b1;
      // Set after clear so a same-cycle issue of the retiring register stays pending
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0, ex_ready = 1'b1, wb_valid = 1'b0;
  logic [31:0] if_ir = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;
  logic        if_ready, ex_valid, illegal_seen;
  logic [31:0] ex_ir, ex_instr_id, ex_rs, ex_rt;
  logic [4:0]  ex_dst;

  decode_stage #(.NREG(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ir(if_ir), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_ir(ex_ir), .ex_instr_id(ex_instr_id), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pend;
  logic        m_valid, m_ill, armed, last_ready;
  logic [31:0] m_ir, m_id, m_rs, m_rt;
  logic [4:0]  m_dst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int op, input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // id 0 means not decodable; kind: 0 register, 1 sign-ext imm, 2 zero-ext imm, 3 shamt
  function automatic void ref_decode(input logic [31:0] ir, output logic [31:0] id, output int kind);
    int op, fn;
    op = int'(ir[31:26]);
    fn = int'(ir[5:0]);
    id = 0;
    kind = 0;
    if (op == 0 && fn < 4) id = 32'(fn + 1);
    else if (op == 1) begin id = 5; kind = 1; end
    else if (op == 2) begin id = 6; kind = 2; end
    else if (op == 3 && fn == 0) id = 7;
    else if (op == 4 && fn == 0) id = 8;
    else if (op == 5) begin id = 9; kind = 2; end
    else if (op == 6) begin id = 10; kind = 2; end
    else if (op == 7 && fn == 0) begin id = 11; kind = 3; end
    else if (op == 7 && fn == 1) begin id = 12; kind = 3; end
    else if (op == 19 && fn == 0) id = 24;
    else if (op == 20) begin id = 25; kind = 1; end
  endfunction

  function automatic logic wb_hits(input logic [4:0] r);
    return wb_valid && !reset && (wb_addr == r);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    return wb_hits(r) ? wb_data : m_rf[r];
  endfunction

  function automatic logic is_busy(input logic [4:0] r);
    return m_pend[r] && !wb_hits(r);
  endfunction

  function automatic logic [4:0] ref_dst(input logic [31:0] ir, input int kind);
    return (kind == 0) ? ir[15:11] : ir[20:16];
  endfunction

  function automatic logic model_ready();
    logic [31:0] id;
    int kind;
    logic hz;
    ref_decode(if_ir, id, kind);
    hz = (id != 0) && (is_busy(if_ir[25:21]) || is_busy(ref_dst(if_ir, kind)) ||
                       (kind == 0 && is_busy(if_ir[20:16])));
    return !reset && (!m_valid || ex_ready) && !hz;
  endfunction

  task automatic model_update(input logic rdy);
    logic [31:0] id, b;
    int kind;
    logic acc, iss;
    logic [4:0] d;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_pend = 0; m_valid = 0; m_ill = 0;
      m_ir = 0; m_id = 0; m_rs = 0; m_rt = 0; m_dst = 0;
      return;
    end
    ref_decode(if_ir, id, kind);
    acc = if_valid && rdy;
    iss = acc && (id != 0);
    d = ref_dst(if_ir, kind);
    case (kind)
      1: b = {{16{if_ir[15]}}, if_ir[15:0]};
      2: b = {16'd0, if_ir[15:0]};
      3: b = {27'd0, if_ir[10:6]};
      default: b = rf_read(if_ir[20:16]);
    endcase
    if (!m_valid || ex_ready) m_valid = iss;
    if (iss) begin
      m_ir = if_ir; m_id = id; m_rs = rf_read(if_ir[25:21]); m_rt = b; m_dst = d;
    end
    if (acc && id == 0) m_ill = 1;
    if (wb_valid) begin
      m_pend[wb_addr] = 0;
      m_rf[wb_addr] = wb_data;
    end
    if (iss) m_pend[d] = 1;
  endtask

  task automatic compare_outputs();
    if (!armed) return;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("illegal_seen", 32'(illegal_seen), 32'(m_ill));
    if (m_valid) begin
      chk("ex_ir", ex_ir, m_ir);
      chk("ex_instr_id", ex_instr_id, m_id);
      chk("ex_rs", ex_rs, m_rs);
      chk("ex_rt", ex_rt, m_rt);
      chk("ex_dst", 32'(ex_dst), 32'(m_dst));
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [31:0] ir, input logic er,
                      input logic wv, input logic [4:0] wa, input logic [31:0] wd);
    logic exp_rdy;
    @(negedge clk);
    compare_outputs();
    reset = rst; if_valid = iv; if_ir = ir; ex_ready = er;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    #1;
    exp_rdy = model_ready();
    last_ready = if_ready;
    if (armed) chk("if_ready", 32'(if_ready), 32'(exp_rdy));
    @(posedge clk);
    model_update(exp_rdy);
    armed = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 1, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    int r1, r2, r3;
    r1 = int'($urandom_range(0, 7));
    r2 = int'($urandom_range(0, 7));
    r3 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0:  return rtype(0, r1, r2, r3, 0, int'($urandom_range(0, 3)));
      1:  return itype(1, r1, r3, int'($urandom_range(0, 65535)));
      2:  return itype(2, r1, r3, int'($urandom_range(0, 65535)));
      3:  return rtype(3, r1, r2, r3, 0, 0);
      4:  return rtype(4, r1, r2, r3, 0, 0);
      5:  return itype(5, r1, r3, int'($urandom_range(0, 65535)));
      6:  return itype(6, r1, r3, int'($urandom_range(0, 65535)));
      7:  return rtype(7, r1, r3, 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
      8:  return rtype(19, r1, r2, r3, 0, 0);
      9:  return itype(20, r1, r3, int'($urandom_range(0, 65535)));
      10: return rtype(0, r1, r2, r3, 0, int'($urandom_range(0, 63)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] or_ir, add_ir, sub_ir;
    logic [4:0]  pend_q[$];
    logic        rst, iv, er, wv;
    logic [4:0]  wa;
    armed = 1'b0;
    m_valid = 0; m_ill = 0; m_pend = 0;

    // Reset and zero read
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 5, 32'h1234);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_ir", ex_ir, 0);
    chk("rst_ex_rt", ex_rt, 0);
    chk("rst_illegal", 32'(illegal_seen), 0);
    step(0, 1, rtype(0, 1, 2, 3, 0, 0), 1, 0, 0, 0);
    #1;
    chk("t1_valid", 32'(ex_valid), 1);
    chk("t1_id", ex_instr_id, 1);
    chk("t1_rs", ex_rs, 0);
    chk("t1_rt", ex_rt, 0);
    chk("t1_dst", 32'(ex_dst), 3);

    // Immediate extension
    step(0, 0, 0, 1, 1, 1, 5);
    step(0, 1, itype(1, 1, 5, 16'hFFFF), 1, 0, 0, 0);
    #1;
    chk("t2_addi_rs", ex_rs, 5);
    chk("t2_addi_rt", ex_rt, 32'hFFFF_FFFF);
    chk("t2_addi_id", ex_instr_id, 5);
    step(0, 1, itype(5, 1, 6, 16'hFFFF), 1, 0, 0, 0);
    #1;
    chk("t2_andi_rt", ex_rt, 32'h0000_FFFF);
    chk("t2_andi_id", ex_instr_id, 9);

    // RAW stall, released by writeback with bypass
    sub_ir = rtype(0, 3, 1, 4, 0, 1);
    step(0, 1, sub_ir, 1, 0, 0, 0);
    #1;
    chk("t3_stall_ready", 32'(last_ready), 0);
    chk("t3_stall_valid", 32'(ex_valid), 0);
    step(0, 1, sub_ir, 1, 0, 0, 0);
    step(0, 1, sub_ir, 1, 1, 3, 7);
    #1;
    chk("t3_issue_ready", 32'(last_ready), 1);
    chk("t3_id", ex_instr_id, 2);
    chk("t3_rs_bypass", ex_rs, 7);
    chk("t3_rt", ex_rt, 5);

    // Output backpressure
    or_ir  = rtype(4, 1, 1, 8, 0, 0);
    add_ir = rtype(0, 1, 1, 9, 0, 0);
    step(0, 1, or_ir, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, add_ir, 0, 0, 0, 0);
      #1;
      chk("t4_hold_ir", ex_ir, or_ir);
      chk("t4_hold_ready", 32'(last_ready), 0);
    end
    step(0, 1, add_ir, 1, 0, 0, 0);
    #1;
    chk("t4_release_ir", ex_ir, add_ir);
    idle();
    #1;
    chk("t4_drain_valid", 32'(ex_valid), 0);

    // Illegal instruction
    step(0, 1, 32'hFC00_0000, 1, 0, 0, 0);
    #1;
    chk("t5_consumed", 32'(last_ready), 1);
    chk("t5_valid", 32'(ex_valid), 0);
    chk("t5_illegal", 32'(illegal_seen), 1);
    idle();
    idle();
    #1;
    chk("t5_sticky", 32'(illegal_seen), 1);

    // Reset while stalled: instruction stays upstream, then issues afresh
    sub_ir = rtype(0, 10, 1, 11, 0, 1);
    step(0, 1, rtype(0, 1, 2, 10, 0, 0), 1, 0, 0, 0);
    step(0, 1, sub_ir, 1, 0, 0, 0);
    #1;
    chk("rs_stall_ready", 32'(last_ready), 0);
    step(1, 1, sub_ir, 1, 1, 10, 32'h55);
    #1;
    chk("rs_reset_ready", 32'(last_ready), 0);
    chk("rs_illegal_clr", 32'(illegal_seen), 0);
    chk("rs_valid_clr", 32'(ex_valid), 0);
    step(0, 1, sub_ir, 1, 0, 0, 0);
    #1;
    chk("rs_reissue_valid", 32'(ex_valid), 1);
    chk("rs_reissue_rs", ex_rs, 0);

    // Shift and slt decode
    step(0, 1, rtype(7, 1, 7, 0, 4, 1), 1, 0, 0, 0);
    #1;
    chk("t6_srl_id", ex_instr_id, 12);
    chk("t6_srl_rt", ex_rt, 4);
    chk("t6_srl_dst", 32'(ex_dst), 7);
    step(0, 1, rtype(19, 1, 2, 12, 0, 0), 1, 0, 0, 0);
    #1;
    chk("t6_slt_id", ex_instr_id, 24);
    step(0, 1, itype(20, 1, 13, 16'h8000), 1, 0, 0, 0);
    #1;
    chk("t6_slti_rt", ex_rt, 32'hFFFF_8000);
    chk("t6_slti_id", ex_instr_id, 25);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      pend_q.delete();
      for (int r = 0; r < 32; r++) if (m_pend[r]) pend_q.push_back(5'(r));
      rst = ($urandom_range(0, 499) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      er  = ($urandom_range(0, 3) != 0);
      wv  = ($urandom_range(0, 2) == 0);
      if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
        wa = pend_q[$urandom_range(0, pend_q.size() - 1)];
      else
        wa = 5'($urandom_range(0, 7));
      step(rst, iv, rand_instr(), er, wv, wa, $urandom);
    end
    idle();
    idle();
    @(negedge clk);
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand fetch stage placed directly upstream of the ALU. It accepts a 32-bit instruction from fetch, decodes it into the ALU instruction ID, and reads both source operands from a 32-entry register file it owns. Immediates are extended as required, and one registered bundle per instruction is handed to the ALU/execute stage over a valid/ready handshake. A scoreboard stalls read-after-write and write-after-write hazards until writeback retires the pending destination.

## Interface
Parameters:
- NREG, 32, number of architectural registers; index width is 5 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_ir  in  32  instruction word
- if_ready  out  1  stage accepts if_ir this cycle
- ex_valid  out  1  output bundle valid
- ex_ready  in  1  execute stage accepts the bundle
- ex_ir  out  32  registered copy of the instruction
- ex_instr_id  out  32  decoded instruction ID
- ex_rs  out  32  operand 1 value
- ex_rt  out  32  operand 2 value: register value or extended immediate
- ex_dst  out  5  destination register index
- wb_valid  in  1  writeback write strobe
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback data
- illegal_seen  out  1  sticky flag set when an instruction is not decodable

## Operation
- Instruction fields: opcode ir[31:26], rs ir[25:21], rt ir[20:16], rd ir[15:11], shamt ir[10:6], funct ir[5:0], imm ir[15:0].
- Instruction ID map:
  - opcode 0, funct 0..3 → IDs 1..4 (add, sub, addu, subu)
  - opcode 1 → 5 (addi); opcode 2 → 6 (addiu)
  - opcode 3, funct 0 → 7 (and); opcode 4, funct 0 → 8 (or)
  - opcode 5 → 9 (andi); opcode 6 → 10 (ori)
  - opcode 7, funct 0 → 11 (sll); opcode 7, funct 1 → 12 (srl)
  - opcode 19, funct 0 → 24 (slt); opcode 20 → 25 (slti)
- Destinations: R-type writes rd. I-type and shift instructions write the rt field. Sources for I-type and shifts: rs field only.
- Operand rules:
  - R-type: ex_rs = RF[rs], ex_rt = RF[rt].
  - addi, slti: ex_rt = sign-extended imm.
  - addiu, andi, ori: ex_rt = zero-extended imm.
  - sll, srl: ex_rt = zero-extended shamt.
- Illegal instruction (any opcode/funct combination not listed above): consumed when if_ready is high, not forwarded, sets illegal_seen. illegal_seen clears only on reset.
- Register file: all 32 entries are general purpose, with no hardwired zero. Written when wb_valid is high.
- Write-through bypass: a read of wb_addr in the same cycle as the write returns wb_data.
- Scoreboard: one pending bit per register.
  - Set when an instruction issues into the output register.
  - Cleared by wb_valid at wb_addr.
  - If the same register is set and cleared in one cycle, set wins.
- Hazard: a source or the destination has its pending bit set and is not being cleared by writeback this cycle.

## Timing
- Reset values: ex_valid=0; ex_ir, ex_instr_id, ex_rs, ex_rt, ex_dst = 0; illegal_seen=0; scoreboard all clear; all registers 0.
- wb_valid is ignored in a reset cycle.
- load_en = !ex_valid || ex_ready.
- if_ready = load_en && !hazard. Computed combinationally from if_ir.
- An illegal instruction never raises a hazard.
- Latency: one cycle. An instruction accepted at edge N appears on ex_valid after edge N.
- ex_* outputs hold stable while ex_valid && !ex_ready.
- ex_valid drops when the bundle is taken and nothing new is loaded, i.e. when if_valid is low, a hazard is present, or the instruction is illegal.
- Full throughput: back-to-back independent instructions issue one per cycle.
- A dependent instruction issues in the same cycle its producer's writeback occurs, via the bypass.
- Reset mid-stall: the pending instruction stays upstream (not consumed); all state clears.

## Structure
- Shared package decode_pkg:
  - opcode and funct constants
  - instruction ID constants 1..12, 24, 25
  - field bit positions
  - this package is also imported by the ALU top-level.
- Sub-module reg_file: 32x32, two combinational read ports, one synchronous write port, with write-through bypass.
- Decode logic, scoreboard and output register stay in decode_stage.

## Test plan
1. **Reset and zero read.** Apply reset, then issue add (opcode 0, funct 0) with rs=1, rt=2, rd=3. Expect ex_valid=1 next cycle, ex_instr_id=1, ex_rs=0, ex_rt=0, ex_dst=3.
2. **Immediate extension.** Write RF[1]=5 via wb, then issue addi with imm=0xFFFF. Expect ex_rs=5, ex_rt=0xFFFFFFFF. Then issue andi with imm=0xFFFF. Expect ex_rt=0x0000FFFF, id=9.
3. **RAW stall and release.** Issue add r3←r1,r2, then sub r4←r3,r1. Expect if_ready=0 while r3 is pending. Pulse wb_valid with addr=3, data=7. Expect sub issues that cycle with ex_rs=7 (bypass) and id=2.
4. **Output backpressure.** Hold ex_ready=0 for 3 cycles with if_valid=1. Expect ex_* stable and if_ready=0. On release, expect one bundle transferred per cycle with no loss or duplication.
5. **Illegal instruction.** Issue opcode 63. Expect it consumed, ex_valid stays 0, illegal_seen=1 until reset.
6. **Shift and slt decode.** srl with shamt=4 gives id=12, ex_rt=4. slt gives id=24. slti with imm=0x8000 gives ex_rt=0xFFFF8000, id=25.
